cam_apb_ctrl_regs: RTL and testbench

APB slave register bank for one OV5640 camera port. It sits directly downstream of the APB2 address/secure decoder and consumes the decoder's qualified psel/penable. It returns pready and pslverr to the decoder. It exposes camera control, a frame counter with interrupt, and a single-command handshake to the SCCB master.

---
 rtl/cam_apb_pkg.sv | 32 +++
 rtl/cam_sccb_cmd_if.sv | 73 +++++++
 rtl/cam_apb_ctrl_regs.sv | 159 +++++++++++++++
 tb/tb_cam_apb_ctrl_regs.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_apb_pkg.sv
// Shared constants for the OV5640 camera APB register bank.
package cam_apb_pkg;

    // Register offsets (byte addresses, word aligned)
    localparam logic [31:0] OFF_CTRL       = 32'h00;
    localparam logic [31:0] OFF_STATUS     = 32'h04;
    localparam logic [31:0] OFF_SCCB_CMD   = 32'h08;
    localparam logic [31:0] OFF_SCCB_RDATA = 32'h0C;
    localparam logic [31:0] OFF_FRAME_CNT  = 32'h10;
    localparam logic [31:0] OFF_ID         = 32'h14;

    // CTRL bits
    localparam int unsigned CTRL_PWDN    = 0;
    localparam int unsigned CTRL_CAM_RST = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;

    // STATUS bits
    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_ERR   = 1;
    localparam int unsigned ST_FRAME = 2;

    // SCCB_CMD fields
    localparam int unsigned CMD_RD        = 24;
    localparam int unsigned CMD_ADDR_LSB  = 8;
    localparam int unsigned CMD_WDATA_LSB = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } sccb_state_t;

endpackage

// File: rtl/cam_sccb_cmd_if.sv
// Single-outstanding-command handshake towards the SCCB master:
// command latch, req/done FSM, read-data capture and NACK error flag.
module cam_sccb_cmd_if
    import cam_apb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_wr,
    input  logic [24:0] cmd_data,
    input  logic        err_clr,
    input  logic        done,
    input  logic [7:0]  rdata_in,
    input  logic        nack,
    output logic        busy,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        req,
    output logic        rd,
    output logic [15:0] addr,
    output logic [7:0]  wdata
);

    sccb_state_t state, state_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs; req stays up until done
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: if (cmd_wr) state_nxt = S_BUSY;
            S_BUSY: begin
                req  = 1'b1;
                busy = 1'b1;
                if (done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command latch: only loaded from idle, so outputs stay stable while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else if (cmd_wr && state == S_IDLE) begin
            rd    <= cmd_data[CMD_RD];
            addr  <= cmd_data[CMD_ADDR_LSB +: 16];
            wdata <= cmd_data[CMD_WDATA_LSB +: 8];
        end
    end

    // Read data captured on completion of a read command
    always_ff @(posedge clk) begin
        if (rst)                      rdata <= '0;
        else if (busy && done && rd)  rdata <= rdata_in;
    end

    // NACK error flag; a new NACK beats a simultaneous W1C
    always_ff @(posedge clk) begin
        if (rst)                       err <= 1'b0;
        else if (busy && done && nack) err <= 1'b1;
        else if (err_clr)              err <= 1'b0;
    end

endmodule

// File: rtl/cam_apb_ctrl_regs.sv
// APB register bank for one OV5640 camera port: control, frame counter
// with interrupt, and the SCCB command interface.
module cam_apb_ctrl_regs
    import cam_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h0564_0001
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic                  cam_vsync_i,
    output logic                  cam_pwdn_o,
    output logic                  cam_rst_o,
    output logic                  irq_o,
    output logic                  sccb_req_o,
    output logic                  sccb_rd_o,
    output logic [15:0]           sccb_addr_o,
    output logic [7:0]            sccb_wdata_o,
    input  logic                  sccb_done_i,
    input  logic [7:0]            sccb_rdata_i,
    input  logic                  sccb_nack_i
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    logic        access;
    logic [3:0]  wcnt;
    logic [31:0] off;
    logic [31:0] rd_mux;
    logic        dec_err;
    logic        wr_en;
    logic        ctrl_wr, status_wr, cmd_wr, fcnt_wr;
    logic        pwdn, cam_rst, irq_en;
    logic        busy, sccb_err, frame_irq;
    logic [7:0]  sccb_rdata;
    logic        vsync_q, vsync_rise;
    logic [31:0] frame_cnt;
    logic        unused_bits;

    assign access      = psel_i & penable_i;
    assign off         = 32'({paddr_i[ADDR_WIDTH-1:2], 2'b00});
    assign unused_bits = ^{pwdata_i[31:25], paddr_i[1:0]};

    // Access-phase wait counter, parked at WAIT_LAST while the access lasts
    always_ff @(posedge pclk_i) begin
        if (prst_i || !access)      wcnt <= '0;
        else if (wcnt != WAIT_LAST) wcnt <= wcnt + 4'd1;
    end

    assign pready_o = access && (wcnt == WAIT_LAST);

    // Address decode: read mux and error detection
    always_comb begin
        rd_mux  = '0;
        dec_err = 1'b0;
        case (off)
            OFF_CTRL: begin
                rd_mux[CTRL_PWDN]    = pwdn;
                rd_mux[CTRL_CAM_RST] = cam_rst;
                rd_mux[CTRL_IRQ_EN]  = irq_en;
            end
            OFF_STATUS: begin
                rd_mux[ST_BUSY]  = busy;
                rd_mux[ST_ERR]   = sccb_err;
                rd_mux[ST_FRAME] = frame_irq;
            end
            OFF_SCCB_CMD: begin
                rd_mux  = {7'd0, sccb_rd_o, sccb_addr_o, sccb_wdata_o};
                dec_err = pwrite_i & busy;
            end
            OFF_SCCB_RDATA: begin
                rd_mux  = {24'd0, sccb_rdata};
                dec_err = pwrite_i;
            end
            OFF_FRAME_CNT: rd_mux = frame_cnt;
            OFF_ID: begin
                rd_mux  = ID_VALUE;
                dec_err = pwrite_i;
            end
            default: dec_err = 1'b1;
        endcase
    end

    assign pslverr_o = pready_o & dec_err;
    assign prdata_o  = (pready_o && !pwrite_i && !dec_err) ? rd_mux : 32'd0;

    assign wr_en     = pready_o & pwrite_i & ~dec_err;
    assign ctrl_wr   = wr_en && (off == OFF_CTRL);
    assign status_wr = wr_en && (off == OFF_STATUS);
    assign cmd_wr    = wr_en && (off == OFF_SCCB_CMD);
    assign fcnt_wr   = wr_en && (off == OFF_FRAME_CNT);

    // CTRL register; camera held powered down and in reset out of reset
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            pwdn    <= 1'b1;
            cam_rst <= 1'b1;
            irq_en  <= 1'b0;
        end else if (ctrl_wr) begin
            pwdn    <= pwdata_i[CTRL_PWDN];
            cam_rst <= pwdata_i[CTRL_CAM_RST];
            irq_en  <= pwdata_i[CTRL_IRQ_EN];
        end
    end

    assign cam_pwdn_o = pwdn;
    assign cam_rst_o  = cam_rst;

    assign vsync_rise = cam_vsync_i & ~vsync_q;

    // VSYNC edge detect, frame counter (clear beats increment), frame flag (set beats W1C)
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
            frame_irq <= 1'b0;
        end else begin
            vsync_q <= cam_vsync_i;
            if (fcnt_wr)         frame_cnt <= '0;
            else if (vsync_rise) frame_cnt <= frame_cnt + 32'd1;
            if (vsync_rise)                         frame_irq <= 1'b1;
            else if (status_wr && pwdata_i[ST_FRAME]) frame_irq <= 1'b0;
        end
    end

    // Registered interrupt output
    always_ff @(posedge pclk_i) begin
        if (prst_i) irq_o <= 1'b0;
        else        irq_o <= frame_irq & irq_en;
    end

    cam_sccb_cmd_if u_sccb (
        .clk      (pclk_i),
        .rst      (prst_i),
        .cmd_wr   (cmd_wr),
        .cmd_data (pwdata_i[24:0]),
        .err_clr  (status_wr & pwdata_i[ST_ERR]),
        .done     (sccb_done_i),
        .rdata_in (sccb_rdata_i),
        .nack     (sccb_nack_i),
        .busy     (busy),
        .err      (sccb_err),
        .rdata    (sccb_rdata),
        .req      (sccb_req_o),
        .rd       (sccb_rd_o),
        .addr     (sccb_addr_o),
        .wdata    (sccb_wdata_o)
    );

endmodule

// File: tb/tb_cam_apb_ctrl_regs.sv
// Bench for cam_apb_ctrl_regs: directed scenarios plus a randomized run
// against a register-level reference model. Two instances: zero-wait and 3-wait.
module tb_cam_apb_ctrl_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        psel0, pen0, psel3, pen3, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        vsync, done, nack;
    logic [7:0]  srdata;

    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic        pwdn0, pwdn3, crst0, crst3, irq0, irq3;
    logic        req0, req3, rd0, rd3;
    logic [15:0] saddr0, saddr3;
    logic [7:0]  swdata0, swdata3;

    int total = 0;
    int bad   = 0;

    cam_apb_ctrl_regs #(.ADDR_WIDTH(8), .WAIT_CYCLES(0), .ID_VALUE(32'h0564_0001)) dut0 (
        .pclk_i(clk), .prst_i(rst), .psel_i(psel0), .penable_i(pen0), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata0), .pready_o(pready0),
        .pslverr_o(pslverr0), .cam_vsync_i(vsync), .cam_pwdn_o(pwdn0), .cam_rst_o(crst0),
        .irq_o(irq0), .sccb_req_o(req0), .sccb_rd_o(rd0), .sccb_addr_o(saddr0),
        .sccb_wdata_o(swdata0), .sccb_done_i(done), .sccb_rdata_i(srdata), .sccb_nack_i(nack));

    cam_apb_ctrl_regs #(.ADDR_WIDTH(8), .WAIT_CYCLES(3), .ID_VALUE(32'h0564_0001)) dut3 (
        .pclk_i(clk), .prst_i(rst), .psel_i(psel3), .penable_i(pen3), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata3), .pready_o(pready3),
        .pslverr_o(pslverr3), .cam_vsync_i(vsync), .cam_pwdn_o(pwdn3), .cam_rst_o(crst3),
        .irq_o(irq3), .sccb_req_o(req3), .sccb_rd_o(rd3), .sccb_addr_o(saddr3),
        .sccb_wdata_o(swdata3), .sccb_done_i(done), .sccb_rdata_i(srdata), .sccb_nack_i(nack));

    // One APB transfer on the selected instance. Optionally raises VSYNC with
    // penable so its edge lands on the completing edge of a zero-wait access.
    task automatic apb(input int which, input bit we, input logic [7:0] a,
                       input logic [31:0] wd, input bit vs,
                       output logic [31:0] rdv, output logic err, output int cyc,
                       output logic [1:0] pre);
        logic rdy;
        @(posedge clk); #1;
        if (which == 0) begin psel0 = 1'b1; pen0 = 1'b0; end
        else            begin psel3 = 1'b1; pen3 = 1'b0; end
        pwrite = we; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        if (which == 0) pen0 = 1'b1; else pen3 = 1'b1;
        if (vs) vsync = 1'b1;
        #1;
        cyc = 1;
        rdy = (which == 0) ? pready0 : pready3;
        while (!rdy && cyc < 40) begin
            @(posedge clk); #2;
            cyc++;
            rdy = (which == 0) ? pready0 : pready3;
        end
        if (!rdy) begin
            bad++; total++;
            $display("FAIL apb_timeout addr=%h got pready=0 want 1", a);
        end
        rdv = (which == 0) ? prdata0 : prdata3;
        err = (which == 0) ? pslverr0 : pslverr3;
        pre = (which == 0) ? {crst0, pwdn0} : {crst3, pwdn3};
        @(posedge clk); #1;
        psel0 = 1'b0; pen0 = 1'b0; psel3 = 1'b0; pen3 = 1'b0;
        if (vs) vsync = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
    endtask

    task automatic pulse_done(input logic [7:0] d, input logic n);
        @(posedge clk); #1;
        done = 1'b1; srdata = d; nack = n;
        @(posedge clk); #1;
        done = 1'b0; nack = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; logic e; int c; logic [1:0] p;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({pwdn0, crst0, irq0, req0, rd0, pready0, pslverr0} !== 7'b1100000) begin
            bad++; $display("FAIL reset_bits got %b want 1100000",
                            {pwdn0, crst0, irq0, req0, rd0, pready0, pslverr0});
        end
        total++;
        if ({prdata0, saddr0, swdata0} !== 56'd0) begin
            bad++; $display("FAIL reset_buses got %h want 0", {prdata0, saddr0, swdata0});
        end
        rst = 1'b0;
        apb(0, 0, 8'h00, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h3 || e !== 1'b0 || c != 1) begin
            bad++; $display("FAIL reset_ctrl got %h/%b/%0d want 3/0/1", r, e, c);
        end
        apb(0, 0, 8'h14, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h0564_0001 || e !== 1'b0 || c != 1) begin
            bad++; $display("FAIL reset_id got %h/%b/%0d want 05640001/0/1", r, e, c);
        end
        apb(0, 0, 8'h10, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h0 || e !== 1'b0) begin
            bad++; $display("FAIL reset_fcnt got %h/%b want 0/0", r, e);
        end
    endtask

    task automatic test_wait();
        logic [31:0] r; logic e; int c; logic [1:0] p;
        apb(3, 1, 8'h00, 32'h4, 0, r, e, c, p);
        total++;
        if (c != 4 || p !== 2'b11 || e !== 1'b0) begin
            bad++; $display("FAIL wait_write got cyc=%0d pre=%b err=%b want 4/11/0", c, p, e);
        end
        total++;
        if ({crst3, pwdn3} !== 2'b00) begin
            bad++; $display("FAIL wait_ctrl_out got %b want 00", {crst3, pwdn3});
        end
        apb(3, 0, 8'h00, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h4 || c != 4) begin
            bad++; $display("FAIL wait_readback got %h/%0d want 4/4", r, c);
        end
    endtask

    task automatic test_sccb();
        logic [31:0] r; logic e; int c; logic [1:0] p;
        apb(0, 1, 8'h08, 32'h0130_0A5A, 0, r, e, c, p);
        total++;
        if ({req0, rd0, saddr0, swdata0} !== {1'b1, 1'b1, 16'h300A, 8'h5A}) begin
            bad++; $display("FAIL sccb_req got %b %b %h %h want 1 1 300a 5a", req0, rd0, saddr0, swdata0);
        end
        apb(0, 0, 8'h04, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h1) begin bad++; $display("FAIL sccb_busy got %h want 1", r); end
        apb(0, 1, 8'h08, 32'h0000_1234, 0, r, e, c, p);
        total++;
        if (e !== 1'b1 || {req0, rd0, saddr0, swdata0} !== {1'b1, 1'b1, 16'h300A, 8'h5A}) begin
            bad++; $display("FAIL sccb_busy_write got err=%b addr=%h want 1 300a", e, saddr0);
        end
        apb(0, 0, 8'h08, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h0130_0A5A) begin bad++; $display("FAIL sccb_cmd_rb got %h want 01300a5a", r); end
        pulse_done(8'h56, 1'b1);
        total++;
        if (req0 !== 1'b0) begin bad++; $display("FAIL sccb_done_req got %b want 0", req0); end
        apb(0, 0, 8'h0C, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h56) begin bad++; $display("FAIL sccb_rdata got %h want 56", r); end
        apb(0, 0, 8'h04, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h2) begin bad++; $display("FAIL sccb_nack_status got %h want 2", r); end
        apb(0, 1, 8'h04, 32'h2, 0, r, e, c, p);
        apb(0, 0, 8'h04, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL sccb_w1c got %h want 0", r); end
    endtask

    task automatic test_frame();
        logic [31:0] r; logic e; int c; logic [1:0] p;
        apb(0, 1, 8'h00, 32'h4, 0, r, e, c, p);
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
        total++;
        if (irq0 !== 1'b0) begin bad++; $display("FAIL frame_irq_early got %b want 0", irq0); end
        @(posedge clk); #1;
        total++;
        if (irq0 !== 1'b1) begin bad++; $display("FAIL frame_irq got %b want 1", irq0); end
        pulse_vsync();
        pulse_vsync();
        apb(0, 0, 8'h10, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'd3) begin bad++; $display("FAIL frame_cnt3 got %h want 3", r); end
        apb(0, 1, 8'h04, 32'h4, 1, r, e, c, p);
        apb(0, 0, 8'h04, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h4) begin bad++; $display("FAIL frame_set_wins got %h want 4", r); end
        apb(0, 0, 8'h10, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'd4) begin bad++; $display("FAIL frame_cnt4 got %h want 4", r); end
        apb(0, 1, 8'h10, 32'hFFFF_FFFF, 1, r, e, c, p);
        apb(0, 0, 8'h10, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL frame_clr_wins got %h want 0", r); end
        total++;
        if (irq0 !== 1'b1) begin bad++; $display("FAIL frame_irq_hold got %b want 1", irq0); end
    endtask

    task automatic test_errors();
        logic [31:0] r; logic e; int c; logic [1:0] p;
        apb(0, 0, 8'h20, 0, 0, r, e, c, p);
        total++;
        if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL err_unmapped got %b/%h want 1/0", e, r); end
        apb(0, 1, 8'h14, 32'hFFFF_FFFF, 0, r, e, c, p);
        total++;
        if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL err_id_write got %b/%h want 1/0", e, r); end
        apb(0, 1, 8'h0C, 32'hFF, 0, r, e, c, p);
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL err_rdata_write got %b want 1", e); end
        apb(0, 1, 8'h20, 32'h0, 0, r, e, c, p);
        apb(0, 0, 8'h00, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h4) begin bad++; $display("FAIL err_ctrl_kept got %h want 4", r); end
        apb(0, 0, 8'h0C, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h56) begin bad++; $display("FAIL err_rdata_kept got %h want 56", r); end
        apb(0, 0, 8'h14, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h0564_0001) begin bad++; $display("FAIL err_id_kept got %h want 05640001", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic e; int c; logic [1:0] p;
        apb(0, 1, 8'h08, 32'h0000_1234, 0, r, e, c, p);
        total++;
        if (req0 !== 1'b1) begin bad++; $display("FAIL rstmid_req_up got %b want 1", req0); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({req0, pwdn0, crst0, saddr0} !== {3'b011, 16'h0}) begin
            bad++; $display("FAIL rstmid_outs got %b%b%b %h want 011 0000", req0, pwdn0, crst0, saddr0);
        end
        rst = 1'b0;
        apb(0, 0, 8'h04, 0, 0, r, e, c, p);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL rstmid_status got %h want 0", r); end
    endtask

    // Reference model of the register bank's visible state
    bit          m_pwdn, m_crst, m_irqen, m_busy, m_err, m_frame;
    logic [31:0] m_cmd, m_fcnt;
    logic [7:0]  m_rdata;

    task automatic model_reset();
        m_pwdn = 1; m_crst = 1; m_irqen = 0; m_busy = 0; m_err = 0; m_frame = 0;
        m_cmd = 0; m_fcnt = 0; m_rdata = 0;
    endtask

    task automatic model_access(input bit we, input logic [7:0] a, input logic [31:0] wd,
                                output logic [31:0] er, output logic ee);
        er = 0; ee = 0;
        case (a & 8'hFC)
            8'h00: if (we) {m_irqen, m_crst, m_pwdn} = wd[2:0];
                   else er = {m_irqen, m_crst, m_pwdn};
            8'h04: if (we) begin
                       if (wd[1]) m_err = 0;
                       if (wd[2]) m_frame = 0;
                   end else er = 4 * m_frame + 2 * m_err + m_busy;
            8'h08: if (we) begin
                       if (m_busy) ee = 1;
                       else begin m_cmd = wd % 32'h0200_0000; m_busy = 1; end
                   end else er = m_cmd;
            8'h0C: if (we) ee = 1; else er = m_rdata;
            8'h10: if (we) m_fcnt = 0; else er = m_fcnt;
            8'h14: if (we) ee = 1; else er = 32'h0564_0001;
            default: ee = 1;
        endcase
    endtask

    task automatic test_random();
        logic [31:0] r, er; logic e, ee; int c; logic [1:0] p;
        logic [7:0] alist [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20, 8'hFC, 8'h40};
        do_reset();
        model_reset();
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [7:0] a;
            logic [31:0] wd;
            op = $urandom_range(0, 9);
            a  = alist[$urandom_range(0, 9)] + 8'($urandom_range(0, 3));
            wd = $urandom;
            if (op <= 6) begin
                bit we;
                we = (op >= 4);
                model_access(we, a, wd, er, ee);
                apb(0, we, a, wd, 0, r, e, c, p);
                total++;
                if (r !== er || e !== ee) begin
                    bad++; $display("FAIL rnd_access it=%0d we=%0d a=%h got %h/%b want %h/%b",
                                    i, we, a, r, e, er, ee);
                end
            end else if (op == 7) begin
                pulse_vsync();
                m_fcnt = m_fcnt + 1;
                m_frame = 1;
            end else if (op == 8) begin
                logic [7:0] d; logic n;
                d = 8'($urandom); n = 1'($urandom);
                pulse_done(d, n);
                if (m_busy) begin
                    m_busy = 0;
                    if (m_cmd[24]) m_rdata = d;
                    if (n) m_err = 1;
                end
            end
            @(posedge clk); #1;
            total++;
            if ({pwdn0, crst0, req0, rd0, saddr0, swdata0, irq0} !==
                {m_pwdn, m_crst, m_busy, m_cmd[24], m_cmd[23:8], m_cmd[7:0], m_frame & m_irqen}) begin
                bad++; $display("FAIL rnd_outs it=%0d got %b%b%b%b %h %h %b want %b%b%b%b %h %h %b",
                                i, pwdn0, crst0, req0, rd0, saddr0, swdata0, irq0,
                                m_pwdn, m_crst, m_busy, m_cmd[24], m_cmd[23:8], m_cmd[7:0],
                                m_frame & m_irqen);
            end
        end
    endtask

    initial begin
        rst = 1'b0; psel0 = 0; pen0 = 0; psel3 = 0; pen3 = 0; pwrite = 0;
        paddr = 0; pwdata = 0; vsync = 0; done = 0; nack = 0; srdata = 0;
        test_reset();
        test_wait();
        test_sccb();
        test_frame();
        test_errors();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
